// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   - ks_state_e : key-schedule controller FSM states
//   - AES128_NR  : number of expansion rounds for AES-128
//   - RCON_INIT  : first round constant
//   - GF_POLY    : reduction term of the AES field polynomial x^8+x^4+x^3+x+1
//   - xtime()    : multiply a field element by x
package aes_pkg;

  localparam int         AES128_NR = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_POLY   = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return b[7] ? ({b[6:0], 1'b0} ^ GF_POLY) : {b[6:0], 1'b0};
  endfunction

endpackage

// File: rtl/rcon_gen.sv
// Round-constant generator: one byte register stepped by xtime.
// Ports:
//   clk     in  clock
//   rst     in  asynchronous active-low reset (rc returns to RCON_INIT)
//   init    in  reload RCON_INIT (takes priority over advance)
//   advance in  step rc to xtime(rc)
//   rc      out current round constant byte
module rcon_gen
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       advance,
  output logic [7:0] rc
);

  logic [7:0] rc_q;
  logic [7:0] rc_d;

  always_comb begin
    rc_d = rc_q;
    if (init) begin
      rc_d = RCON_INIT;
    end else if (advance) begin
      rc_d = xtime(rc_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rc_q <= RCON_INIT;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc = rc_q;

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES key-schedule controller. Accepts a cipher key, drives an external
// expansion stage one round at a time (ROUND_CYC cycles per round) and
// captures every returned round key into a register-array store that can
// be read back with one cycle of latency.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   key_valid/key_ready  key handshake; key_in[127:120] is key byte 0
//   kx_load              one-cycle load strobe to the expansion stage
//   kx_key               registered copy of the accepted key
//   kx_rcon              {rc, 24'h0} while expanding, zero otherwise
//   kx_key_out           round key returned by the expansion stage
//   rk_addr / rk_data    round-key read port (registered, 0 beyond NR)
//   busy                 schedule in progress (LOAD or RUN)
//   sched_done           all NR+1 round keys stored
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NR        = AES128_NR,
  parameter int ROUND_CYC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         kx_load,
  output logic [127:0] kx_key,
  output logic [31:0]  kx_rcon,
  input  logic [127:0] kx_key_out,
  input  logic [3:0]   rk_addr,
  output logic [127:0] rk_data,
  output logic         busy,
  output logic         sched_done
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [2:0] LAST_CYC   = 3'(ROUND_CYC - 1);

  ks_state_e    state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [127:0] kx_key_q, kx_key_d;
  logic         key_ready_q, key_ready_d;
  logic [127:0] rk_q [NR+1];
  logic [127:0] rk_d [NR+1];
  logic [127:0] rk_data_q, rk_data_d;
  logic         accept;
  logic         rc_init;
  logic         rc_adv;
  logic         rk_wr;
  logic [7:0]   rc;

  rcon_gen u_rcon_gen (
    .clk     (clk),
    .rst     (rst),
    .init    (rc_init),
    .advance (rc_adv),
    .rc      (rc)
  );

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    cnt_d    = cnt_q;
    kx_key_d = kx_key_q;
    rc_init  = 1'b0;
    rc_adv   = 1'b0;
    rk_wr    = 1'b0;
    accept   = key_valid && key_ready_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d  = ST_LOAD;
          round_d  = 4'd1;
          cnt_d    = '0;
          kx_key_d = key_in;
          rc_init  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
      ST_RUN: begin
        // The expansion stage result is only valid on the last cycle of
        // each round window; capture it there and step to the next round.
        if (cnt_q == LAST_CYC) begin
          rk_wr  = 1'b1;
          rc_adv = 1'b1;
          cnt_d  = '0;
          if (round_q == LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered so that it stays low through reset and rises on the
    // first clock edge after release.
    key_ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);

    rk_d = rk_q;
    if (accept) begin
      rk_d[0] = key_in;
    end
    if (rk_wr) begin
      rk_d[round_q] = kx_key_out;
    end

    // Reads see the pre-write contents, so a same-cycle write returns old data.
    rk_data_d = (rk_addr <= LAST_ROUND) ? rk_q[rk_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      round_q     <= '0;
      cnt_q       <= '0;
      kx_key_q    <= '0;
      key_ready_q <= 1'b0;
      rk_data_q   <= '0;
      for (int i = 0; i <= NR; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      cnt_q       <= cnt_d;
      kx_key_q    <= kx_key_d;
      key_ready_q <= key_ready_d;
      rk_data_q   <= rk_data_d;
      rk_q        <= rk_d;
    end
  end

  assign key_ready  = key_ready_q;
  assign kx_load    = (state_q == ST_LOAD);
  assign kx_key     = kx_key_q;
  assign kx_rcon    = (state_q == ST_RUN) ? {rc, 24'h0} : 32'h0;
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign sched_done = (state_q == ST_DONE);
  assign rk_data    = rk_data_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed bench for key_schedule_ctrl. Three instances (ROUND_CYC = 2, 1, 3)
// share stimulus; each has a behavioural AES expansion stage that presents a
// valid round key only on the last cycle of a round window.
module tb_key_schedule_ctrl;

  localparam int NI = 3;

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] RK1_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_K1 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] RK10_K2 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         key_valid;
  logic [127:0] key_in;
  logic [3:0]   rk_addr;

  logic [NI-1:0]        key_ready_v, kx_load_v, busy_v, sched_done_v;
  logic [NI-1:0][127:0] kx_key_v, kx_key_out_v, rk_data_v;
  logic [NI-1:0][31:0]  kx_rcon_v;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);  // a^254 = inverse (0 -> 0)
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, r, t;
    {w0, w1, w2, w3} = k;
    r  = {w3[23:0], w3[31:24]};
    t  = {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int RC = (g == 0) ? 2 : (g == 1) ? 1 : 3;
    logic [127:0] cur;
    logic [127:0] nxt;
    int           mcnt = 0;

    key_schedule_ctrl #(.NR(10), .ROUND_CYC(RC)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_ready  (key_ready_v[g]),
      .key_in     (key_in),
      .kx_load    (kx_load_v[g]),
      .kx_key     (kx_key_v[g]),
      .kx_rcon    (kx_rcon_v[g]),
      .kx_key_out (kx_key_out_v[g]),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data_v[g]),
      .busy       (busy_v[g]),
      .sched_done (sched_done_v[g])
    );

    assign nxt             = expand_round(cur, kx_rcon_v[g][31:24]);
    assign kx_key_out_v[g] = (mcnt == RC - 1) ? nxt : ~nxt;

    always @(posedge clk) begin
      if (kx_load_v[g]) begin
        cur  <= kx_key_v[g];
        mcnt <= 0;
      end else if (kx_rcon_v[g] != 32'h0) begin
        if (mcnt == RC - 1) begin
          cur  <= nxt;
          mcnt <= 0;
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                               8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  logic [31:0] rq[$];
  int          lat [NI];
  int          loads;
  int          bad_hold;

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_in    = '0;
    rk_addr   = 4'd0;
    for (int g = 0; g < NI; g++) lat[g] = 0;
    loads    = 0;
    bad_hold = 0;

    // Reset state
    step(); step(); step();
    chk("rst_key_ready", key_ready_v[0], 1'b0);
    chk("rst_busy", busy_v[0], 1'b0);
    chk("rst_sched_done", sched_done_v[0], 1'b0);
    chk("rst_kx_load", kx_load_v[0], 1'b0);
    chk("rst_kx_key", kx_key_v[0], '0);
    chk("rst_kx_rcon", kx_rcon_v[0], '0);
    chk("rst_rk_data", rk_data_v[0], '0);

    rst = 1'b1;
    #1;
    chk("ready_before_edge", key_ready_v[0], 1'b0);
    step();
    chk("ready_after_release", key_ready_v[0], 1'b1);
    chk("rk0_cleared", rk_data_v[0], '0);

    // First schedule with K1 on all three instances
    key_valid = 1'b1;
    key_in    = K1;
    step();
    key_valid = 1'b0;
    chk("load_strobe", kx_load_v[0], 1'b1);
    chk("load_busy", busy_v[0], 1'b1);
    chk("load_ready", key_ready_v[0], 1'b0);
    chk("load_rcon_zero", kx_rcon_v[0], '0);
    chk("kx_key_latched", kx_key_v[0], K1);
    for (int i = 1; i <= 40; i++) begin
      step();
      for (int g = 0; g < NI; g++) begin
        if (lat[g] == 0 && sched_done_v[g]) lat[g] = i;
      end
      if (kx_rcon_v[0] != 32'h0) rq.push_back(kx_rcon_v[0]);
      if (kx_load_v[0]) loads++;
    end
    chk("latency_rc2", lat[0], 21);
    chk("latency_rc1", lat[1], 11);
    chk("latency_rc3", lat[2], 31);
    chk("load_once", loads, 0);
    chk("done_held", sched_done_v[0], 1'b1);
    chk("done_rcon_zero", kx_rcon_v[0], '0);
    chk("done_busy", busy_v[0], 1'b0);
    chk("rcon_count", rq.size(), 20);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("rcon_%0d", i), (i < rq.size()) ? rq[i] : 32'hxxxxxxxx,
          {rc_tab[i / 2], 24'h0});
    end

    // Round-key read back
    rk_addr = 4'd1;
    step();
    for (int g = 0; g < NI; g++) chk($sformatf("rk1_inst%0d", g), rk_data_v[g], RK1_K1);
    rk_addr = 4'd10;
    step();
    for (int g = 0; g < NI; g++) chk($sformatf("rk10_inst%0d", g), rk_data_v[g], RK10_K1);
    for (int a = 11; a <= 15; a++) begin
      rk_addr = 4'(a);
      step();
      chk($sformatf("rk_oob_%0d", a), rk_data_v[0], '0);
    end

    // Second key from DONE while another key is held pending through RUN
    rk_addr   = 4'd0;
    key_valid = 1'b1;
    key_in    = K2;
    step();
    key_in = K1;
    chk("rk0_old_same_cycle", rk_data_v[0], K1);
    chk("done_cleared", sched_done_v[0], 1'b0);
    chk("kx_key_k2", kx_key_v[0], K2);
    step();
    chk("rk0_new", rk_data_v[0], K2);
    for (int i = 2; i <= 20; i++) begin
      step();
      if (kx_key_v[0] !== K2 || key_ready_v[0] !== 1'b0) bad_hold++;
    end
    chk("held_key_ignored", bad_hold, 0);
    step();
    chk("k2_done", sched_done_v[0], 1'b1);
    chk("k2_done_ready", key_ready_v[0], 1'b1);
    step();
    key_valid = 1'b0;
    chk("pending_accepted", kx_key_v[0], K1);
    chk("pending_done_drop", sched_done_v[0], 1'b0);
    chk("pending_busy", busy_v[0], 1'b1);
    rk_addr = 4'd0;
    step();
    chk("rk0_overwritten", rk_data_v[0], K1);
    rk_addr = 4'd10;
    for (int i = 2; i <= 21; i++) step();
    chk("rk10_write_done", sched_done_v[0], 1'b1);
    chk("rk10_old_same_cycle", rk_data_v[0], RK10_K2);
    step();
    chk("rk10_new", rk_data_v[0], RK10_K1);

    // Reset in the middle of round 5
    key_valid = 1'b1;
    key_in    = K2;
    step();
    key_valid = 1'b0;
    for (int i = 1; i <= 10; i++) step();
    chk("pre_abort_rcon", kx_rcon_v[0], {8'h10, 24'h0});
    rst = 1'b0;
    #1;
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_rcon", kx_rcon_v[0], '0);
    chk("abort_kx_key", kx_key_v[0], '0);
    chk("abort_ready", key_ready_v[0], 1'b0);
    chk("abort_rk_data", rk_data_v[0], '0);
    step();
    rst = 1'b1;
    rk_addr = 4'd1;
    step();
    chk("abort_ready_back", key_ready_v[0], 1'b1);
    chk("abort_rk1_cleared", rk_data_v[0], '0);
    rk_addr = 4'd0;
    step();
    chk("abort_rk0_cleared", rk_data_v[0], '0);

    key_valid = 1'b1;
    key_in    = K1;
    step();
    key_valid = 1'b0;
    rk_addr   = 4'd10;
    for (int i = 1; i <= 40; i++) step();
    for (int g = 0; g < NI; g++) chk($sformatf("rerun_rk10_inst%0d", g), rk_data_v[g], RK10_K1);
    for (int g = 0; g < NI; g++) chk($sformatf("rerun_done_inst%0d", g), sched_done_v[g], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
